// File: rtl/freq_meter.sv
// Gate-window frequency meter: counts synchronised rising edges of sig_in over a
// selectable window of clk cycles. Optional period measurement: FREQ_METER_PERIOD_EN.
module freq_meter #(
    parameter int GATE_CYCLES = 60_000_000,
    parameter int CNT_W       = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic [1:0]       gate_sel,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy,
    output logic [CNT_W-1:0] period_cnt,
    output logic             period_valid
);

    localparam int GCW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GCW-1:0]   LAST0   = GCW'(GATE_CYCLES - 1);
    localparam logic [GCW-1:0]   LAST1   = GCW'(GATE_CYCLES / 10 - 1);
    localparam logic [GCW-1:0]   LAST2   = GCW'(GATE_CYCLES / 100 - 1);
    localparam logic [GCW-1:0]   LAST3   = GCW'(GATE_CYCLES / 1000 - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_GATE  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    function automatic logic [GCW-1:0] gate_last(input logic [1:0] sel);
        logic [GCW-1:0] r;
        case (sel)
            2'd0:    r = LAST0;
            2'd1:    r = LAST1;
            2'd2:    r = LAST2;
            2'd3:    r = LAST3;
            default: r = LAST0;
        endcase
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               s_dly_q;
    logic               rise_s;
    logic [GCW-1:0]     gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic               ovf_flag_q, ovf_flag_d;
    logic [CNT_W-1:0]   freq_cnt_q, freq_cnt_d;
    logic               overflow_q, overflow_d;
    logic               freq_valid_q, freq_valid_d;
    logic               busy_q, busy_d;

    assign rise_s = sync_q[SYNC_STAGES-1] & ~s_dly_q;

    // Synchroniser chain plus one delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{1'b0}};
            s_dly_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ARM;
            gate_cnt_q   <= {GCW{1'b0}};
            edge_cnt_q   <= {CNT_W{1'b0}};
            ovf_flag_q   <= 1'b0;
            freq_cnt_q   <= {CNT_W{1'b0}};
            overflow_q   <= 1'b0;
            freq_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            ovf_flag_q   <= ovf_flag_d;
            freq_cnt_q   <= freq_cnt_d;
            overflow_q   <= overflow_d;
            freq_valid_q <= freq_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARM:   state_d = ST_GATE;
            ST_GATE: begin
                if (gate_cnt_q == {GCW{1'b0}}) begin
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_GATE;
                end
            end
            ST_LATCH: state_d = ST_ARM;
            default:  state_d = ST_ARM;
        endcase
    end

    // Gate countdown, saturating edge count and result capture
    always_comb begin
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_flag_d = ovf_flag_q;
        freq_cnt_d = freq_cnt_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_ARM: begin
                gate_cnt_d = gate_last(gate_sel);
                edge_cnt_d = {CNT_W{1'b0}};
                ovf_flag_d = 1'b0;
            end
            ST_GATE: begin
                if (rise_s) begin
                    if (edge_cnt_q == CNT_MAX) begin
                        ovf_flag_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    edge_cnt_d = edge_cnt_q;
                end
                if (gate_cnt_q != {GCW{1'b0}}) begin
                    gate_cnt_d = gate_cnt_q - {{(GCW-1){1'b0}}, 1'b1};
                end else begin
                    gate_cnt_d = gate_cnt_q;
                end
            end
            ST_LATCH: begin
                freq_cnt_d = edge_cnt_q;
                overflow_d = ovf_flag_q;
            end
            default: begin
                gate_cnt_d = gate_cnt_q;
            end
        endcase
    end

    // Output decode; valid is registered so it lines up with the updated result
    always_comb begin
        busy_d       = (state_d == ST_GATE);
        freq_valid_d = (state_q == ST_LATCH);
    end

    assign freq_cnt   = freq_cnt_q;
    assign overflow   = overflow_q;
    assign freq_valid = freq_valid_q;
    assign busy       = busy_q;

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             period_valid_q, period_valid_d;

    // Period counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q      <= {CNT_W{1'b0}};
            seen_q         <= 1'b0;
            period_cnt_q   <= {CNT_W{1'b0}};
            period_valid_q <= 1'b0;
        end else begin
            per_cnt_q      <= per_cnt_d;
            seen_q         <= seen_d;
            period_cnt_q   <= period_cnt_d;
            period_valid_q <= period_valid_d;
        end
    end

    // First rise only arms the measurement; later rises report the interval
    always_comb begin
        per_cnt_d      = per_cnt_q;
        seen_d         = seen_q;
        period_cnt_d   = period_cnt_q;
        period_valid_d = 1'b0;
        if (rise_s) begin
            per_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            seen_d    = 1'b1;
            if (seen_q) begin
                period_cnt_d   = per_cnt_q;
                period_valid_d = 1'b1;
            end else begin
                period_valid_d = 1'b0;
            end
        end else if (per_cnt_q != CNT_MAX) begin
            per_cnt_d = per_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            per_cnt_d = per_cnt_q;
        end
    end

    assign period_cnt   = period_cnt_q;
    assign period_valid = period_valid_q;
`else
    assign period_cnt   = {CNT_W{1'b0}};
    assign period_valid = 1'b0;
`endif

endmodule
